wb_rr_arbiter4: RTL

- Four-master, one-slave Wishbone (classic pipelined) arbiter for shared CPU/peripheral buses, e.g. ZipCPU fetch, load/store, debug and DMA masters onto one memory bus.
- Grant is round-robin, registered and held for a master's whole cycle.
- Tracks outstanding strobes and aborts hung slaves with a timeout error.
- Replaces fixed-priority two-master arbitration where more than two masters share a resource.

---
 rtl/wb_rr_arbiter4.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter4.sv
// Four-master to one-slave pipelined Wishbone arbiter with a registered round-robin grant,
// outstanding-strobe tracking and a hung-slave timeout abort.
module wb_rr_arbiter4 #(
  parameter int AW      = 19,
  parameter int DW      = 32,
  parameter int LGOUT   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_m_cyc,
  input  logic [3:0]      i_m_stb,
  input  logic [3:0]      i_m_we,
  input  logic [4*AW-1:0] i_m_adr,
  input  logic [4*DW-1:0] i_m_dat,
  output logic [3:0]      o_m_ack,
  output logic [3:0]      o_m_stall,
  output logic [3:0]      o_m_err,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_adr,
  output logic [DW-1:0]   o_dat,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err,
  output logic [3:0]      o_grant,
  output logic            o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_ABORT} state_t;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LGOUT-1:0] CNT_MAX  = {LGOUT{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [LGOUT-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic       own_cyc, own_stb, full, bus_cyc, timeout_hit, stb_go, accept;
  logic       pick_valid;
  logic [1:0] pick_idx;

  assign own_cyc     = i_m_cyc[owner_q];
  assign own_stb     = i_m_stb[owner_q];
  assign full        = (cnt_q == CNT_MAX);
  assign bus_cyc     = (state_q == S_BUS) && own_cyc;
  assign timeout_hit = bus_cyc && (cnt_q != '0) && !i_ack && !i_err && (tmo_q == TMO_LAST);
  assign stb_go      = bus_cyc && !timeout_hit && own_stb && !full;
  assign accept      = stb_go && !i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Scan last+4 down to last+1 so the first requester after the previous owner wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    for (int i = 4; i >= 1; i--) begin
      if (i_m_cyc[last_q + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = last_q + 2'(i);
      end
    end
  end

  // The GAP cycle is the one dead bus cycle and also arbitrates, so a waiting
  // master owns the bus two cycles after the previous owner drops CYC.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE, S_GAP: begin
        cnt_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        if (!own_cyc) begin
          state_d = S_GAP;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else begin
          if (i_err) begin
            cnt_d = '0;
          end else if (accept && !i_ack) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!accept && i_ack && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
          end
          if ((cnt_q != '0) && !i_ack && !i_err) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_ABORT: begin
        cnt_d = '0;
        if (!own_cyc) begin
          state_d = S_GAP;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_m_ack   = 4'b0000;
    o_m_err   = 4'b0000;
    o_m_stall = 4'b1111;
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = 1'b0;
    o_adr     = i_m_adr[owner_q*AW +: AW];
    o_dat     = i_m_dat[owner_q*DW +: DW];
    o_grant   = 4'b0000;
    o_timeout = 1'b0;
    case (state_q)
      S_BUS: begin
        o_grant            = 4'b0001 << owner_q;
        o_cyc              = bus_cyc && !timeout_hit;
        o_stb              = stb_go;
        o_we               = i_m_we[owner_q];
        o_m_stall[owner_q] = i_stall || full || timeout_hit;
        o_m_ack[owner_q]   = i_ack && !timeout_hit;
        o_m_err[owner_q]   = i_err || timeout_hit;
        o_timeout          = timeout_hit;
      end
      S_ABORT: o_grant = 4'b0001 << owner_q;
      default: ;
    endcase
  end

endmodule
